// File: rtl/insfetch.sv
// Instruction fetch stage for the 8-thread barrel pipeline: per-thread PCs, active mask,
// round-robin thread pick and the IF/ID register. Optional macro IF_MISALIGN_CHK_EN adds misalign_dec.
module insfetch #(
   parameter int          NUM_TRD = 8,
   parameter logic [31:0] RST_PC  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flushIF,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        jmp_en,
   input  logic [2:0]  jmp_trd,
   input  logic [31:0] jmp_pc,
   input  logic        init_trd_dec,
   input  logic [31:0] init_pc,
   input  logic        kill_en,
   input  logic [2:0]  kill_trd,
   output logic [31:0] ins_dec,
   output logic [31:0] pc_dec,
   output logic [2:0]  trd_dec,
   output logic        valid_dec,
   output logic [2:0]  new_trd_id,
   output logic        no_free_trd
`ifdef IF_MISALIGN_CHK_EN
   ,
   output logic        misalign_dec
`endif
);

   logic [31:0]        pc_r [NUM_TRD];
   logic [NUM_TRD-1:0] active_r;
   logic [2:0]         last_r;

   logic [NUM_TRD-1:0] eff_mask_s;
   logic [NUM_TRD-1:0] next_mask_s;
   logic [2:0]         sel_s;
   logic [2:0]         idx_s;
   logic               found_s;
   logic               any_s;
   logic [2:0]         new_id_s;
   logic               full_s;
   logic               fetch_s;
   logic               init_ok_s;

   // Eligible threads this cycle: a kill takes effect immediately.
   always_comb begin
      eff_mask_s = active_r;
      if (kill_en) begin
         eff_mask_s[kill_trd] = 1'b0;
      end else begin
         eff_mask_s = active_r;
      end
   end

   // Round-robin pick starting one past the last issued thread; offset 8 wraps back to last_r.
   always_comb begin
      sel_s   = 3'd0;
      idx_s   = 3'd0;
      found_s = 1'b0;
      for (int k = 1; k <= NUM_TRD; k++) begin
         idx_s = last_r + 3'(k);
         if (!found_s && eff_mask_s[idx_s]) begin
            sel_s   = idx_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Lowest free thread comes from the pre-kill mask so an init never lands on kill_trd.
   always_comb begin
      new_id_s = 3'd0;
      for (int i = NUM_TRD - 1; i >= 0; i--) begin
         new_id_s = active_r[i] ? new_id_s : 3'(i);
      end
   end

   assign any_s       = |eff_mask_s;
   assign full_s      = &active_r;
   assign fetch_s     = !stall && !flushIF && any_s;
   assign init_ok_s   = init_trd_dec && !full_s;
   assign new_trd_id  = new_id_s;
   assign no_free_trd = full_s;
   assign imem_addr   = pc_r[sel_s];

   // Next active mask: kill clears, a granted init sets.
   always_comb begin
      next_mask_s = active_r;
      if (kill_en) begin
         next_mask_s[kill_trd] = 1'b0;
      end else begin
         next_mask_s = next_mask_s;
      end
      if (init_ok_s) begin
         next_mask_s[new_id_s] = 1'b1;
      end else begin
         next_mask_s = next_mask_s;
      end
   end

   // Per-thread PC update: redirect beats init beats sequential increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TRD; i++) begin
            pc_r[i] <= (i == 0) ? RST_PC : 32'd0;
         end
      end else begin
         for (int i = 0; i < NUM_TRD; i++) begin
            if (jmp_en && (jmp_trd == 3'(i))) begin
               pc_r[i] <= jmp_pc;
            end else if (init_ok_s && (new_id_s == 3'(i))) begin
               pc_r[i] <= init_pc;
            end else if (fetch_s && (sel_s == 3'(i))) begin
               pc_r[i] <= pc_r[i] + 32'd4;
            end else begin
               pc_r[i] <= pc_r[i];
            end
         end
      end
   end

   // Active mask and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_r <= NUM_TRD'(1);
         last_r   <= 3'd7;
      end else begin
         active_r <= next_mask_s;
         if (fetch_s) begin
            last_r <= sel_s;
         end else begin
            last_r <= last_r;
         end
      end
   end

   // IF/ID pipeline register; a flush wins over a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ins_dec      <= 32'd0;
         pc_dec       <= 32'd0;
         trd_dec      <= 3'd0;
         valid_dec    <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
         misalign_dec <= 1'b0;
`endif
      end else if (flushIF || (!stall && !any_s)) begin
         ins_dec      <= 32'd0;
         pc_dec       <= 32'd0;
         trd_dec      <= 3'd0;
         valid_dec    <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
         misalign_dec <= 1'b0;
`endif
      end else if (stall) begin
         ins_dec      <= ins_dec;
         pc_dec       <= pc_dec;
         trd_dec      <= trd_dec;
         valid_dec    <= valid_dec;
`ifdef IF_MISALIGN_CHK_EN
         misalign_dec <= misalign_dec;
`endif
      end else begin
         ins_dec      <= imem_data;
         pc_dec       <= imem_addr;
         trd_dec      <= sel_s;
         valid_dec    <= 1'b1;
`ifdef IF_MISALIGN_CHK_EN
         misalign_dec <= |imem_addr[1:0];
`endif
      end
   end

endmodule

// File: tb/tb_insfetch.sv
// Scoreboard bench for insfetch: a behavioural thread model queues the expected IF/ID contents
// each cycle; scenario tasks pop and compare, plus fixed-value checks from the test plan.
module tb_insfetch;

   localparam logic [31:0] KEY = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flushIF, jmp_en, init_trd_dec, kill_en;
   logic [2:0]  jmp_trd, kill_trd;
   logic [31:0] jmp_pc, init_pc;
   logic [31:0] imem_addr, imem_data;
   logic [31:0] ins_dec, pc_dec;
   logic [2:0]  trd_dec, new_trd_id;
   logic        valid_dec, no_free_trd;
`ifdef IF_MISALIGN_CHK_EN
   logic        misalign_dec;
`endif

   insfetch dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flushIF(flushIF),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .jmp_en(jmp_en), .jmp_trd(jmp_trd), .jmp_pc(jmp_pc),
      .init_trd_dec(init_trd_dec), .init_pc(init_pc),
      .kill_en(kill_en), .kill_trd(kill_trd),
      .ins_dec(ins_dec), .pc_dec(pc_dec), .trd_dec(trd_dec), .valid_dec(valid_dec),
      .new_trd_id(new_trd_id), .no_free_trd(no_free_trd)
`ifdef IF_MISALIGN_CHK_EN
      , .misalign_dec(misalign_dec)
`endif
   );

   always #5 clk = ~clk;
   assign imem_data = imem_addr ^ KEY;

   typedef logic [67:0] ifid_t;
   ifid_t       sb_q[$];
   ifid_t       e;
   wire  [67:0] got = {valid_dec, trd_dec, pc_dec, ins_dec};

   int          n_vec = 0;
   int          n_err = 0;

   logic [7:0]  m_active;
   logic [31:0] m_pc [8];
   int          m_last;
   ifid_t       m_out;

   function automatic int peek_sel(input logic [7:0] mask);
      for (int k = 1; k <= 8; k++) begin
         if (mask[(m_last + k) % 8]) return (m_last + k) % 8;
      end
      return -1;
   endfunction

   task automatic idle();
      stall = 1'b0; flushIF = 1'b0; jmp_en = 1'b0; init_trd_dec = 1'b0; kill_en = 1'b0;
      jmp_trd = 3'd0; kill_trd = 3'd0; jmp_pc = 32'd0; init_pc = 32'd0;
   endtask

   // Predict this cycle from the model and current inputs, queue it, then clock once.
   task automatic step();
      logic [7:0] eff;
      int s, nid;
      bit init_ok, fetch;
      ifid_t x;
      eff = m_active;
      if (kill_en) eff[kill_trd] = 1'b0;
      s = peek_sel(eff);
      nid = 8;
      for (int i = 7; i >= 0; i--) if (!m_active[i]) nid = i;
      init_ok = init_trd_dec && (nid < 8);
      fetch = !stall && !flushIF && (s >= 0);
      if (flushIF) x = '0;
      else if (stall) x = m_out;
      else if (s >= 0) x = {1'b1, 3'(s), m_pc[s], m_pc[s] ^ KEY};
      else x = '0;
      m_out = x;
      sb_q.push_back(x);
      if (fetch) begin m_pc[s] = m_pc[s] + 32'd4; m_last = s; end
      if (init_ok) m_pc[nid] = init_pc;
      if (jmp_en) m_pc[jmp_trd] = jmp_pc;
      if (kill_en) m_active[kill_trd] = 1'b0;
      if (init_ok) m_active[nid] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #12;
      n_vec++;
      if (got !== 68'd0 || new_trd_id !== 3'd1 || no_free_trd !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state got=%h nid=%0d full=%b exp=0/1/0", got, new_trd_id, no_free_trd);
      end
      m_active = 8'h01; m_last = 7; m_out = '0;
      for (int i = 0; i < 8; i++) m_pc[i] = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL reset_seq got=%h exp=%h", got, e); end
         n_vec++;
         if (trd_dec !== 3'd0 || pc_dec !== 32'(4 * i) || valid_dec !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pc cyc%0d got trd=%0d pc=%h v=%b exp trd=0 pc=%h v=1", i, trd_dec, pc_dec, valid_dec, 4 * i);
         end
      end
   endtask

   task automatic test_init();
      logic [2:0]  exp_trd [4] = '{3'd1, 3'd0, 3'd1, 3'd0};
      n_vec++;
      if (new_trd_id !== 3'd1) begin n_err++; $display("FAIL init_nid_pre got=%0d exp=1", new_trd_id); end
      init_trd_dec = 1'b1; init_pc = 32'h100;
      step();
      init_trd_dec = 1'b0;
      e = sb_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL init_cycle got=%h exp=%h", got, e); end
      n_vec++;
      if (new_trd_id !== 3'd2) begin n_err++; $display("FAIL init_nid_post got=%0d exp=2", new_trd_id); end
      for (int i = 0; i < 4; i++) begin
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL init_seq got=%h exp=%h", got, e); end
         n_vec++;
         if (trd_dec !== exp_trd[i]) begin n_err++; $display("FAIL init_alt cyc%0d got=%0d exp=%0d", i, trd_dec, exp_trd[i]); end
         if (i == 0 || i == 2) begin
            n_vec++;
            if (pc_dec !== (32'h100 + 32'(2 * i))) begin
               n_err++; $display("FAIL init_t1pc got=%h exp=%h", pc_dec, 32'h100 + 32'(2 * i));
            end
         end
      end
   endtask

   task automatic test_kill();
      logic [2:0] exp_trd [4] = '{3'd0, 3'd2, 3'd0, 3'd2};
      bit hit = 1'b0;
      init_trd_dec = 1'b1; init_pc = 32'h300;
      step();
      init_trd_dec = 1'b0;
      e = sb_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL kill_init got=%h exp=%h", got, e); end
      for (int i = 0; i < 8 && !hit; i++) begin
         if (peek_sel(m_active) == 1) hit = 1'b1;
         else begin
            step();
            e = sb_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL kill_pre got=%h exp=%h", got, e); end
         end
      end
      kill_en = 1'b1; kill_trd = 3'd1;
      step();
      kill_en = 1'b0;
      e = sb_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL kill_cycle got=%h exp=%h", got, e); end
      n_vec++;
      if (trd_dec !== 3'd2 || valid_dec !== 1'b1) begin n_err++; $display("FAIL kill_skip got trd=%0d v=%b exp trd=2 v=1", trd_dec, valid_dec); end
      for (int i = 0; i < 4; i++) begin
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL kill_seq got=%h exp=%h", got, e); end
         n_vec++;
         if (trd_dec !== exp_trd[i]) begin n_err++; $display("FAIL kill_order cyc%0d got=%0d exp=%0d", i, trd_dec, exp_trd[i]); end
      end
   endtask

   task automatic test_jmp();
      bit seen = 1'b0;
      for (int i = 0; i < 4 && peek_sel(m_active) != 0; i++) begin
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL jmp_pre got=%h exp=%h", got, e); end
      end
      jmp_en = 1'b1; jmp_trd = 3'd0; jmp_pc = 32'h40;
      step();
      jmp_en = 1'b0;
      e = sb_q.pop_front(); n_vec++;
      if (got !== e || trd_dec !== 3'd0) begin n_err++; $display("FAIL jmp_cycle got=%h exp=%h", got, e); end
      for (int i = 0; i < 3 && !seen; i++) begin
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL jmp_seq got=%h exp=%h", got, e); end
         if (valid_dec && trd_dec == 3'd0) begin
            seen = 1'b1; n_vec++;
            if (pc_dec !== 32'h40) begin n_err++; $display("FAIL jmp_target got=%h exp=00000040", pc_dec); end
         end
      end
      n_vec++;
      if (!seen) begin n_err++; $display("FAIL jmp_timeout got=no_t0_issue exp=t0_issue"); end
   endtask

   task automatic test_flush();
      flushIF = 1'b1;
      step();
      e = sb_q.pop_front(); n_vec++;
      if (got !== e || got !== 68'd0) begin n_err++; $display("FAIL flush_bubble got=%h exp=%h", got, e); end
      flushIF = 1'b0;
      step();
      e = sb_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL flush_resume got=%h exp=%h", got, e); end
      stall = 1'b1; flushIF = 1'b1;
      step();
      flushIF = 1'b0;
      e = sb_q.pop_front(); n_vec++;
      if (got !== e || valid_dec !== 1'b0) begin n_err++; $display("FAIL flush_stall got=%h exp=%h", got, e); end
      step();
      stall = 1'b0;
      e = sb_q.pop_front(); n_vec++;
      if (got !== e || got !== 68'd0) begin n_err++; $display("FAIL flush_hold got=%h exp=%h", got, e); end
      step();
      e = sb_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL flush_after got=%h exp=%h", got, e); end
   endtask

   task automatic test_stall();
      logic [31:0] h_ins, h_pc;
      bit seen = 1'b0;
      h_ins = ins_dec; h_pc = pc_dec;
      stall = 1'b1; init_trd_dec = 1'b1; init_pc = 32'h500;
      for (int i = 0; i < 2; i++) begin
         step();
         init_trd_dec = 1'b0;
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL stall_sb got=%h exp=%h", got, e); end
         n_vec++;
         if (ins_dec !== h_ins || pc_dec !== h_pc) begin
            n_err++; $display("FAIL stall_hold got ins=%h pc=%h exp ins=%h pc=%h", ins_dec, pc_dec, h_ins, h_pc);
         end
      end
      stall = 1'b0;
      n_vec++;
      if (new_trd_id !== 3'd3) begin n_err++; $display("FAIL stall_nid got=%0d exp=3", new_trd_id); end
      for (int i = 0; i < 4 && !seen; i++) begin
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL stall_seq got=%h exp=%h", got, e); end
         if (valid_dec && trd_dec == 3'd1) begin
            seen = 1'b1; n_vec++;
            if (pc_dec !== 32'h500) begin n_err++; $display("FAIL stall_newpc got=%h exp=00000500", pc_dec); end
         end
      end
      n_vec++;
      if (!seen) begin n_err++; $display("FAIL stall_timeout got=no_t1_issue exp=t1_issue"); end
   endtask

   task automatic test_full();
      logic [7:0] seen = 8'd0;
      for (int i = 0; i < 8 && !no_free_trd; i++) begin
         init_trd_dec = 1'b1; init_pc = 32'h1000 + 32'(i * 16);
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL full_fill got=%h exp=%h", got, e); end
      end
      n_vec++;
      if (no_free_trd !== 1'b1) begin n_err++; $display("FAIL full_flag got=%b exp=1", no_free_trd); end
      init_pc = 32'hBAD0;
      step();
      init_trd_dec = 1'b0;
      e = sb_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL full_drop got=%h exp=%h", got, e); end
      for (int i = 0; i < 8; i++) begin
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e || pc_dec == 32'hBAD0) begin n_err++; $display("FAIL full_rr got=%h exp=%h", got, e); end
         seen[trd_dec] = 1'b1;
      end
      n_vec++;
      if (seen !== 8'hFF) begin n_err++; $display("FAIL full_fair got=%h exp=ff", seen); end
   endtask

   task automatic test_kill_all();
      for (int i = 0; i < 8; i++) begin
         kill_en = 1'b1; kill_trd = 3'(i);
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e) begin n_err++; $display("FAIL killall_seq got=%h exp=%h", got, e); end
      end
      kill_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         e = sb_q.pop_front(); n_vec++;
         if (got !== e || valid_dec !== 1'b0 || ins_dec !== 32'd0) begin
            n_err++; $display("FAIL killall_bubble got=%h exp=%h", got, e);
         end
      end
      n_vec++;
      if (new_trd_id !== 3'd0 || no_free_trd !== 1'b0) begin n_err++; $display("FAIL killall_nid got=%0d exp=0", new_trd_id); end
      init_trd_dec = 1'b1; init_pc = 32'h200;
      step();
      init_trd_dec = 1'b0;
      e = sb_q.pop_front(); n_vec++;
      if (got !== e || valid_dec !== 1'b0) begin n_err++; $display("FAIL restart_cycle got=%h exp=%h", got, e); end
      step();
      e = sb_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL restart_sb got=%h exp=%h", got, e); end
      n_vec++;
      if (valid_dec !== 1'b1 || trd_dec !== 3'd0 || pc_dec !== 32'h200 || ins_dec !== (32'h200 ^ KEY)) begin
         n_err++; $display("FAIL restart_issue got v=%b trd=%0d pc=%h exp v=1 trd=0 pc=00000200", valid_dec, trd_dec, pc_dec);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_kill();
      test_jmp();
      test_flush();
      test_stall();
      test_full();
      test_kill_all();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/insfetch.md
Name: insfetch

Overview:
- Instruction fetch stage for the 8-thread barrel pipeline; directly upstream of the instruction decode/register stage.
- Holds one PC per hardware thread and an active-thread mask.
- Each cycle, picks the next active thread round-robin, reads instruction memory, and registers ins/pc/thread into the IF/ID pipeline register.
- Supplies decode with the lowest free thread ID for thread creation, and accepts PC redirects and thread kills from later stages.

Parameters:
- NUM_TRD, 8, number of hardware threads; fixed by 3-bit thread IDs, must be 8.
- RST_PC, 32'h0000_0000, PC loaded into thread 0 at reset.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold the IF/ID register and all PCs; no scheduler advance
- flushIF  in  1  load a bubble into the IF/ID register this cycle
- imem_addr  out  32  fetch address, combinational = pc[sel]
- imem_data  in  32  instruction word, combinational read of imem_addr
- jmp_en  in  1  PC redirect request
- jmp_trd  in  3  thread being redirected
- jmp_pc  in  32  redirect target
- init_trd_dec  in  1  decode requests thread creation
- init_pc  in  32  start PC of the new thread
- kill_en  in  1  terminate a thread
- kill_trd  in  3  thread to terminate
- ins_dec  out  32  registered instruction to decode
- pc_dec  out  32  registered PC of ins_dec
- trd_dec  out  3  registered thread ID of ins_dec
- valid_dec  out  1  ins_dec is a real instruction
- new_trd_id  out  3  lowest-index inactive thread, combinational from the mask
- no_free_trd  out  1  all 8 threads active

Behaviour:
- Reset (async): active mask = 8'b0000_0001; pc[0] = RST_PC; pc[1..7] = 0; round-robin pointer last = 7.
- Reset values of the registered outputs: ins_dec, pc_dec, trd_dec, valid_dec = 0.
- Thread selection, combinational:
  - eff_mask = active & ~(kill_en ? onehot(kill_trd) : 0).
  - sel = first set bit of eff_mask searching last+1, last+2, … with wrap 7→0.
  - any = |eff_mask.
- Normal cycle (!stall, !flushIF, any):
  - ins_dec <= imem_data; pc_dec <= pc[sel]; trd_dec <= sel; valid_dec <= 1.
  - pc[sel] <= pc[sel] + 4 (32-bit wrap); last <= sel.
- No active thread (!any, !stall): ins_dec, pc_dec, trd_dec, valid_dec <= 0; last unchanged.
- flushIF && !stall:
  - IF/ID register loads a bubble (all 0).
  - PC increment and pointer advance are suppressed.
  - Redirect, init and kill still apply.
- flushIF && stall: flush wins; bubble loaded.
- stall without flushIF:
  - IF/ID register, PCs from increment, and last all hold.
  - jmp, init and kill still update PCs and the mask.
- PC write priority per thread, highest first: jmp_en to that thread > init to that thread > +4 increment.
- Redirect to an inactive thread updates its PC; the mask is unchanged.
- Init:
  - If init_trd_dec && !no_free_trd: active[new_trd_id] <= 1 and pc[new_trd_id] <= init_pc.
  - New thread is eligible from the next cycle.
  - If no_free_trd, the init is silently dropped.
- Kill:
  - active[kill_trd] <= 0.
  - The killed thread is excluded from selection in the same cycle.
  - Killing thread 0 is allowed; all-inactive is a legal state, producing continuous bubbles.
- Init and kill in the same cycle:
  - new_trd_id is computed from the pre-kill mask, so init never targets kill_trd.
  - Both apply.
- Fetch latency: one cycle from selection to ins_dec.
- Each active thread is fetched at most once every N cycles when N threads are active.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Defined:
  - Adds output misalign_dec (1 bit), registered with the IF/ID register.
  - misalign_dec = |pc[sel][1:0]; reset and bubble value 0.
  - A misaligned fetch still issues, with valid_dec = 1.
- Undefined: port absent; no alignment logic.

Test Plan:
- Reset then 3 cycles -> trd_dec = 0 each cycle; pc_dec = 0, 4, 8; valid_dec = 1.
- Init with init_pc = 32'h100 at cycle 1 -> new_trd_id = 1 before init, 2 after. Issue alternates thread 0/1; thread 1 pc_dec = 0x100, 0x104.
- Threads 0, 1, 2 active; kill_trd = 1 in the cycle thread 1 would be selected -> thread 2 issues instead. Sequence continues 0, 2, 0, 2.
- jmp_en to thread 0 with jmp_pc = 32'h40 in the same cycle thread 0 is fetched -> next thread-0 pc_dec = 0x40, not the incremented value.
- stall held 2 cycles with init active -> ins_dec/pc_dec unchanged. New thread is active and is issued after stall drops.
- Kill the only active thread -> valid_dec = 0 and ins_dec = 0 every cycle. Init with init_pc = 32'h200 -> thread 0 issues from 0x200.
